// File: rtl/rib_sram_resp.sv
// Word-addressed SRAM responder for the core's data port.
// It adds a fixed number of wait states, and all outputs are registered.
module rib_sram_resp #(
  parameter int unsigned DEPTH       = 4096,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        err_o,
  output logic        busy_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [29:0] idx_q;
  logic [31:0] wdata_q;

  logic        take;
  logic        enter_ack;
  logic        acc_we;
  logic [29:0] acc_idx;
  logic [31:0] acc_data;
  logic        in_range;
  logic        mem_we;
  logic [31:0] rdata;

  logic [31:0] mem [DEPTH];

  logic unused_addr;
  assign unused_addr = ^addr_i[1:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    take      = 1'b0;
    enter_ack = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          take = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d   = ST_ACK;
            enter_ack = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = 4'(WAIT_CYCLES);
          end
        end
      end
      ST_WAIT: begin
        if (!req_i) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d   = ST_ACK;
            enter_ack = 1'b1;
          end
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // With zero wait states, the completing edge is also the accepting edge.
  // The live inputs then stand in for the latched copies.
  always_comb begin
    acc_we   = take ? we_i         : we_q;
    acc_idx  = take ? addr_i[31:2] : idx_q;
    acc_data = take ? data_i       : wdata_q;
    in_range = 32'(acc_idx) < DEPTH;
    mem_we   = rst && enter_ack && acc_we && in_range;
    rdata    = mem[acc_idx[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[acc_idx[AW-1:0]] <= acc_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      ack_o   <= 1'b0;
      err_o   <= 1'b0;
      busy_o  <= 1'b0;
      data_o  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (take) begin
        we_q    <= we_i;
        idx_q   <= addr_i[31:2];
        wdata_q <= data_i;
      end
      ack_o  <= enter_ack;
      err_o  <= enter_ack && !in_range;
      busy_o <= (state_d != ST_IDLE);
      data_o <= (enter_ack && !acc_we && in_range) ? rdata : '0;
    end
  end

endmodule

// File: tb/tb_rib_sram_resp.sv
// Directed bench for rib_sram_resp.
// One instance uses two wait states and one uses zero wait states.
module tb_rib_sram_resp;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_a = 1'b0;
  logic        req_b = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] data_a, data_b;
  logic        ack_a, ack_b, err_a, err_b, busy_a, busy_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rib_sram_resp #(.DEPTH(4096), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .req_i(req_a), .we_i(we), .addr_i(addr),
    .data_i(wdata), .data_o(data_a), .ack_o(ack_a), .err_o(err_a),
    .busy_o(busy_a)
  );

  rib_sram_resp #(.DEPTH(4096), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req_i(req_b), .we_i(we), .addr_i(addr),
    .data_i(wdata), .data_o(data_b), .ack_o(ack_b), .err_o(err_b),
    .busy_o(busy_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Latency counts the edges from request to the first sample that shows ack.
  task automatic txn(input bit sel, input bit w, input logic [31:0] a, input logic [31:0] d,
                     input int exp_lat, input logic [31:0] exp_data, input bit exp_err,
                     input string tag, input bit chg = 1'b0,
                     input logic [31:0] a2 = '0, input logic [31:0] d2 = '0);
    int n = 0;
    bit got = 1'b0;
    we = w; addr = a; wdata = d;
    if (sel) req_b = 1'b1; else req_a = 1'b1;
    while (n < 20 && !got) begin
      step();
      n++;
      if (chg && n == 1) begin
        addr = a2;
        wdata = d2;
      end
      got = sel ? ack_b : ack_a;
    end
    check({tag, "_lat"}, n, exp_lat);
    check({tag, "_data"}, sel ? data_b : data_a, exp_data);
    check({tag, "_err"}, sel ? err_b : err_a, 32'(exp_err));
    check({tag, "_busy"}, sel ? busy_b : busy_a, 1);
    req_a = 1'b0; req_b = 1'b0;
    step();
    check({tag, "_ack_end"}, sel ? ack_b : ack_a, 0);
    check({tag, "_data_idle"}, sel ? data_b : data_a, 0);
    check({tag, "_busy_idle"}, sel ? busy_b : busy_a, 0);
  endtask

  initial begin
    // A request held high during reset must be ignored.
    // It is accepted at the first edge with rst=1.
    rst = 1'b0; req_a = 1'b1; we = 1'b0; addr = 32'h0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_ack", ack_a, 0);
      check("rst_busy", busy_a, 0);
      check("rst_err", err_a, 0);
      check("rst_data", data_a, 0);
    end
    rst = 1'b1;
    step(); check("post_rst_busy", busy_a, 1); check("post_rst_ack0", ack_a, 0);
    step(); check("post_rst_ack1", ack_a, 0);
    step(); check("post_rst_ack2", ack_a, 1);
    req_a = 1'b0;
    step();

    txn(0, 1, 32'h10, 32'hDEADBEEF, 3, 0, 0, "w10");
    txn(0, 0, 32'h10, 32'h0, 3, 32'hDEADBEEF, 0, "r10");

    txn(0, 1, 32'h0, 32'h11111111, 3, 0, 0, "w0");
    txn(0, 1, 32'h4000, 32'hCAFEF00D, 3, 0, 1, "w4000");
    txn(0, 0, 32'h4000, 32'h0, 3, 0, 1, "r4000");
    txn(0, 0, 32'h0, 32'h0, 3, 32'h11111111, 0, "r0");

    // Abandon a write by dropping req_i in the WAIT state.
    txn(0, 1, 32'h20, 32'h55AA55AA, 3, 0, 0, "w20");
    we = 1'b1; addr = 32'h20; wdata = 32'h12345678; req_a = 1'b1;
    step(); check("abn_busy", busy_a, 1);
    req_a = 1'b0;
    step(); check("abn_ack0", ack_a, 0); check("abn_busy0", busy_a, 0);
    step(); check("abn_ack1", ack_a, 0);
    txn(0, 0, 32'h20, 32'h0, 3, 32'h55AA55AA, 0, "r20");

    // Reset lands on the edge that would have committed the write.
    txn(0, 1, 32'h30, 32'h0BADC0DE, 3, 0, 0, "w30");
    we = 1'b1; addr = 32'h30; wdata = 32'hFFFFFFFF; req_a = 1'b1;
    step(); check("rmid_busy", busy_a, 1);
    step();
    rst = 1'b0; req_a = 1'b0;
    step();
    check("rmid_ack", ack_a, 0); check("rmid_busy0", busy_a, 0);
    check("rmid_err", err_a, 0); check("rmid_data", data_a, 0);
    rst = 1'b1;
    step(); check("rmid_ack2", ack_a, 0);
    txn(0, 0, 32'h30, 32'h0, 3, 32'h0BADC0DE, 0, "r30");
    txn(0, 0, 32'h10, 32'h0, 3, 32'hDEADBEEF, 0, "r10b");

    // Address and data change after the write is accepted.
    txn(0, 1, 32'h44, 32'h77777777, 3, 0, 0, "w44");
    txn(0, 1, 32'h40, 32'hA5A5A5A5, 3, 0, 0, "w40chg", 1'b1, 32'h44, 32'h0);
    txn(0, 0, 32'h40, 32'h0, 3, 32'hA5A5A5A5, 0, "r40");
    txn(0, 0, 32'h44, 32'h0, 3, 32'h77777777, 0, "r44");

    txn(1, 1, 32'h0, 32'h0000AAAA, 1, 0, 0, "b_w0");
    txn(1, 1, 32'h4, 32'h0000BBBB, 1, 0, 0, "b_w4");
    we = 1'b0; addr = 32'h0; req_b = 1'b1;
    step(); check("b2b_ack0", ack_b, 1); check("b2b_data0", data_b, 32'h0000AAAA);
    addr = 32'h4;
    step(); check("b2b_ack1", ack_b, 0); check("b2b_data1", data_b, 0);
    step(); check("b2b_ack2", ack_b, 1); check("b2b_data2", data_b, 32'h0000BBBB);
    req_b = 1'b0;
    step(); check("b2b_ack3", ack_b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
